// File: rtl/updown_counter_pkg.sv
// Shared constants for the parametrised up/down counter.
package updown_counter_pkg;

  // Direction select on the mode input
  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  // Behaviour at the range ends, chosen by the SATURATE parameter
  localparam int WRAP = 0;
  localparam int SAT  = 1;

endpackage : updown_counter_pkg

// File: rtl/updown_counter_step.sv
// Combinational single-step rule: next count and end-of-range event.
module updown_counter_step
  import updown_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = WRAP
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] next_o,
  output logic             event_o
);

  // Up steps treat anything at or above limit as the end of the range.
  // Down steps only hit the end at zero, so a count stranded above a
  // freshly lowered limit walks down without raising an event.
  always_comb begin
    next_o  = count_i;
    event_o = 1'b0;
    if (mode_i == MODE_UP) begin
      if (count_i < limit_i) begin
        next_o = count_i + WIDTH'(1);
      end else begin
        event_o = 1'b1;
        next_o  = (SATURATE == SAT) ? limit_i : '0;
      end
    end else begin
      if (count_i == '0) begin
        event_o = 1'b1;
        next_o  = (SATURATE == SAT) ? '0 : limit_i;
      end else begin
        next_o = count_i - WIDTH'(1);
      end
    end
  end

endmodule : updown_counter_step

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with run-time limit, load, enable,
// wrap/saturate ends and registered event/sticky overflow flags.
module updown_counter_param
  import updown_counter_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int              SATURATE  = WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap_pulse,
  output logic             ovf_sticky
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             pulse_q, pulse_d;
  logic             sticky_q, sticky_d;
  logic [WIDTH-1:0] step_next;
  logic             step_event;
  logic [WIDTH-1:0] load_clamped;

  updown_counter_step #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_step (
    .count_i (count_q),
    .limit_i (limit),
    .mode_i  (mode),
    .next_o  (step_next),
    .event_o (step_event)
  );

  assign load_clamped = (load_val > limit) ? limit : load_val;

  // Next-state selection: load beats enable; a load is never an event.
  always_comb begin
    logic evt;
    evt     = 1'b0;
    count_d = count_q;
    if (load) begin
      count_d = load_clamped;
    end else if (en) begin
      count_d = step_next;
      evt     = step_event;
    end
    pulse_d  = evt;
    sticky_d = (sticky_q & ~clr_ovf) | evt;
  end

  // State registers with synchronous reset that overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= RESET_VAL;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
    end
  end

  assign count      = count_q;
  assign at_max     = (count_q == limit);
  assign at_min     = (count_q == '0);
  assign wrap_pulse = pulse_q;
  assign ovf_sticky = sticky_q;

endmodule : updown_counter_param

// File: tb/tb_updown_counter_param.sv
// Bench: a wrapping and a saturating counter share the same stimulus and
// are both compared every cycle against an arithmetic reference model.
module tb_updown_counter_param;

  logic       clk = 1'b0;
  logic       rst, en, mode, load, clr_ovf;
  logic [7:0] load_val, limit;

  logic [7:0] count_w, count_s;
  logic       at_max_w, at_min_w, pulse_w, sticky_w;
  logic       at_max_s, at_min_s, pulse_s, sticky_s;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: index 0 = wrap instance (reset 0), 1 = saturate (reset 3)
  int m_cnt[2];
  int m_pulse[2];
  int m_sticky[2];
  int m_rv[2]  = '{0, 3};
  int m_sat[2] = '{0, 1};

  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(8), .RESET_VAL(8'd0), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
    .load_val(load_val), .limit(limit), .clr_ovf(clr_ovf),
    .count(count_w), .at_max(at_max_w), .at_min(at_min_w),
    .wrap_pulse(pulse_w), .ovf_sticky(sticky_w)
  );

  updown_counter_param #(.WIDTH(8), .RESET_VAL(8'd3), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
    .load_val(load_val), .limit(limit), .clr_ovf(clr_ovf),
    .count(count_s), .at_max(at_max_s), .at_min(at_min_s),
    .wrap_pulse(pulse_s), .ovf_sticky(sticky_s)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Apply the counter rules to the model using the inputs now on the pins.
  task automatic model_step();
    int lim, lv, ev;
    lim = int'(limit);
    lv  = int'(load_val);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_cnt[i] = m_rv[i]; m_pulse[i] = 0; m_sticky[i] = 0;
      end else begin
        ev = 0;
        if (load) begin
          m_cnt[i] = (lv < lim) ? lv : lim;
        end else if (en) begin
          if (!mode) begin
            if (m_cnt[i] < lim) m_cnt[i] = m_cnt[i] + 1;
            else begin ev = 1; m_cnt[i] = m_sat[i] ? lim : 0; end
          end else begin
            if (m_cnt[i] == 0) begin ev = 1; m_cnt[i] = m_sat[i] ? 0 : lim; end
            else m_cnt[i] = m_cnt[i] - 1;
          end
        end
        m_pulse[i]  = ev;
        m_sticky[i] = ((m_sticky[i] != 0) && !clr_ovf) || (ev != 0) ? 1 : 0;
      end
    end
  endtask

  task automatic chk_one(input int i, input int c, input int amax, input int amin,
                         input int p, input int s);
    string nm;
    nm = (i == 0) ? "wrap" : "sat";
    chk({nm, ".count"},  c,    m_cnt[i]);
    chk({nm, ".at_max"}, amax, (m_cnt[i] == int'(limit)) ? 1 : 0);
    chk({nm, ".at_min"}, amin, (m_cnt[i] == 0) ? 1 : 0);
    chk({nm, ".pulse"},  p,    m_pulse[i]);
    chk({nm, ".sticky"}, s,    m_sticky[i]);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk_one(0, int'(count_w), int'(at_max_w), int'(at_min_w), int'(pulse_w), int'(sticky_w));
    chk_one(1, int'(count_s), int'(at_max_s), int'(at_min_s), int'(pulse_s), int'(sticky_s));
  endtask

  initial begin
    int np;
    rst = 1; en = 0; mode = 0; load = 0; clr_ovf = 0; load_val = 0; limit = 8'd9;
    m_cnt = '{0, 0}; m_pulse = '{0, 0}; m_sticky = '{0, 0};
    tick(); tick();
    chk("rst_count_w", int'(count_w), 0);
    chk("rst_count_s", int'(count_s), 3);

    // Up with limit 9: 0..9 then wrap to 0
    rst = 0; en = 1; mode = 0;
    for (int k = 0; k < 9; k++) tick();
    chk("up_top_w", int'(count_w), 9);
    tick();
    chk("up_wrap_cnt_w", int'(count_w), 0);
    chk("up_wrap_pulse_w", int'(pulse_w), 1);
    tick();
    chk("up_after_pulse_w", int'(pulse_w), 0);
    chk("up_after_sticky_w", int'(sticky_w), 1);

    // Down from 0: wrap to limit, then decrement
    load = 1; load_val = 0; tick(); load = 0;
    mode = 1;
    tick();
    chk("dn_wrap_cnt_w", int'(count_w), 9);
    chk("dn_wrap_pulse_w", int'(pulse_w), 1);
    tick();
    chk("dn_8_w", int'(count_w), 8);
    chk("dn_pulse_clr_w", int'(pulse_w), 0);
    tick();
    chk("dn_7_w", int'(count_w), 7);

    // Saturate with limit 5
    limit = 8'd5; load = 1; load_val = 0; tick(); load = 0;
    mode = 0; np = 0;
    for (int k = 0; k < 8; k++) begin tick(); np += int'(pulse_s); end
    chk("sat_up_cnt", int'(count_s), 5);
    chk("sat_up_atmax", int'(at_max_s), 1);
    chk("sat_up_pulses", np, 3);
    mode = 1; np = 0;
    for (int k = 0; k < 8; k++) begin tick(); np += int'(pulse_s); end
    chk("sat_dn_cnt", int'(count_s), 0);
    chk("sat_dn_atmin", int'(at_min_s), 1);
    chk("sat_dn_pulses", np, 3);

    // Load clamp, lowered limit, wrap from above
    clr_ovf = 1; en = 0; tick(); clr_ovf = 0;
    load = 1; en = 1; load_val = 8'd200; limit = 8'd100; tick();
    chk("ld_clamp_w", int'(count_w), 100);
    chk("ld_no_event_w", int'(pulse_w), 0);
    chk("ld_no_sticky_w", int'(sticky_w), 0);
    load = 0; limit = 8'd50; mode = 1; tick();
    chk("above_dn_w", int'(count_w), 99);
    chk("above_dn_pulse_w", int'(pulse_w), 0);
    mode = 0; tick();
    chk("above_up_w", int'(count_w), 0);
    chk("above_up_pulse_w", int'(pulse_w), 1);
    chk("above_up_s", int'(count_s), 50);

    // Sticky clear alone, then clear colliding with an event
    en = 0; clr_ovf = 1; tick();
    chk("clr_alone_w", int'(sticky_w), 0);
    en = 1; mode = 1; tick();
    chk("clr_vs_event_w", int'(sticky_w), 1);
    clr_ovf = 0;

    // Reset mid-count overrides load/en
    mode = 0; tick(); tick();
    rst = 1; load = 1; load_val = 8'd20; en = 1; tick();
    chk("rst_mid_cnt_s", int'(count_s), 3);
    chk("rst_mid_pulse_s", int'(pulse_s), 0);
    chk("rst_mid_sticky_s", int'(sticky_s), 0);
    rst = 0; load = 0;

    // Randomised traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rst      = ($urandom_range(0, 99) == 0);
      load     = ($urandom_range(0, 7) == 0);
      en       = ($urandom_range(0, 3) != 0);
      mode     = 1'($urandom_range(0, 1));
      clr_ovf  = ($urandom_range(0, 9) == 0);
      load_val = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 31) == 0)
        limit = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                            : 8'($urandom_range(0, 12));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_updown_counter_param

// File: doc/updown_counter_param.md
# updown_counter_param

Parametrised up/down counter, next generation of the team's fixed 8-bit up/down counter. Adds configurable width, a run-time terminal value (limit), synchronous load, count enable, and a choice of wrap or saturate at the range ends. Adds registered event and sticky overflow flags for timer, PWM and address-generator users elsewhere in the design.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (≥2)
- RESET_VAL, 0, value of count after reset (must be ≤ limit in use)
- SATURATE, 0, 0 = wrap at range ends, 1 = hold at range ends

Ports:
- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  synchronous, active-high reset
- en  in  1  count enable; step taken only when high
- mode  in  1  0 = up, 1 = down
- load  in  1  synchronous load strobe
- load_val  in  WIDTH  value loaded when load=1
- limit  in  WIDTH  upper end of count range; range is 0..limit inclusive
- clr_ovf  in  1  clears ovf_sticky
- count  out  WIDTH  current count (registered)
- at_max  out  1  count == limit (combinational decode of count register)
- at_min  out  1  count == 0 (combinational decode)
- wrap_pulse  out  1  registered; high for exactly the cycle after a wrap/saturate event
- ovf_sticky  out  1  registered; set on any wrap/saturate event, held until clr_ovf or rst

## Operation
- Priority per clk edge: rst > load > en. With en=0 and load=0, count holds.
- Reset: count=RESET_VAL, wrap_pulse=0, ovf_sticky=0.
- Load: count = min(load_val, limit). Load is not an event; wrap_pulse=0 and ovf_sticky are unchanged.
- Up step, count < limit: count+1.
- Up step, count ≥ limit: this is an event. SATURATE=0 gives count=0; SATURATE=1 gives count=limit.
- Down step, 0 < count ≤ limit: count−1.
- Down step, count == 0: this is an event. SATURATE=0 gives count=limit; SATURATE=1 gives count=0.
- Down step, count > limit (limit lowered at run time): count−1. This is not an event.
- limit=0: every enabled step is an event. count stays 0 in both SATURATE modes.
- All arithmetic is WIDTH bits unsigned. No intermediate wider than WIDTH+1. No wrap through 2^WIDTH except via the rules above.
- ovf_sticky next value = (ovf_sticky & ~clr_ovf) | event. Set wins over a simultaneous clr_ovf.
- In saturate mode, repeated steps at the end each count as an event, so wrap_pulse stays high while pressed.

## Timing
- count updates on the clk edge where the step, load or reset is sampled: 1-cycle latency from inputs.
- wrap_pulse and ovf_sticky update on the same edge as the count change that caused the event. They are visible together with the new count.
- at_max and at_min follow count combinationally, with no extra latency. They reflect the current limit.
- limit and mode are sampled every edge. Changes take effect on the next step with no pipeline.
- Reset mid-count overrides load, en and clr_ovf on that edge. Outputs are at reset values the following cycle.

## Structure
- Shared package updown_counter_pkg holds:
  - constants MODE_UP=1'b0 and MODE_DOWN=1'b1
  - constants WRAP=0 and SAT=1 for SATURATE
- One natural sub-module: updown_counter_step, combinational, parametrised by WIDTH and SATURATE.
  - Inputs: count, limit, mode.
  - Outputs: next count and event.
  - The top holds the registers, load clamp and flag logic.

## Test plan
- WIDTH=8, limit=9, SATURATE=0, up, en=1 from reset. Required: count 0..9, then 0. wrap_pulse high exactly in the cycle count shows 0. ovf_sticky=1 afterwards.
- Same config, down from 0. Required: count 9, wrap_pulse=1, then 8, 7, … Pulse clears after one cycle.
- SATURATE=1, limit=5, up for 8 cycles. Required: count holds at 5, at_max=1, wrap_pulse high for each of the 3 steps at 5. Then down to 0 and beyond: count holds at 0, at_min=1.
- load=1 and en=1 together, load_val=200, limit=100. Required: count=100, no event. Then lower limit to 50 and step down: count 99, no event. Step up: wrap to 0 with event.
- ovf_sticky set, then clr_ovf pulsed alone. Required: cleared. clr_ovf asserted on the same cycle as an event: remains 1.
- rst asserted mid-count with load=1 and en=1 (RESET_VAL=3). Required: next cycle count=3, wrap_pulse=0, ovf_sticky=0.
